// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - byte-serial instruction fetch FSM with valid/ready output and PC redirect
module if_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter int                MEM_LAT    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                    dclk,
    input  logic                    rst,
    input  logic                    rdy,
    output logic [ADDR_W-1:0]       addr_mem_o,
    output logic                    ce_mem_o,
    input  logic [7:0]              d_mem_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    output logic [8*INST_BYTES-1:0] inst_o,
    output logic [ADDR_W-1:0]       inst_pc_o,
    output logic                    inst_valid_o,
    input  logic                    inst_ready_i
);

    localparam int IDX_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int CNT_W = $clog2(INST_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(INST_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    ce_q;
    logic [IDX_W-1:0]        idx_q;        // byte lane of the address currently presented
    logic [CNT_W-1:0]        issue_cnt_q;  // addresses presented so far for this word
    logic [ADDR_W-1:0]       pc_base_q;
    logic                    tag_v_q   [MEM_LAT];
    logic [IDX_W-1:0]        tag_idx_q [MEM_LAT];
    logic [8*INST_BYTES-1:0] inst_q;
    logic [ADDR_W-1:0]       inst_pc_q;
    logic                    valid_q;

    logic [ADDR_W-1:0]       pc_next_d;
    logic [ADDR_W-1:0]       addr_inc_d;

    assign pc_next_d  = pc_base_q + ADDR_W'(INST_BYTES);
    assign addr_inc_d = addr_q + ADDR_W'(1);

    assign addr_mem_o   = addr_q;
    assign ce_mem_o     = ce_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;

    // Fetch FSM: issue addresses, track in-flight byte tags, assemble and hand off the word.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= RESET_PC;
            ce_q        <= 1'b0;
            idx_q       <= '0;
            issue_cnt_q <= '0;
            pc_base_q   <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_v_q[i]   <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else if (rdy) begin
            if (state_q == S_IDLE) begin
                // Redirect is ignored here; the first fetch always starts at RESET_PC.
                state_q     <= S_FETCH;
                pc_base_q   <= RESET_PC;
                addr_q      <= RESET_PC;
                ce_q        <= 1'b1;
                idx_q       <= '0;
                issue_cnt_q <= CNT_ONE;
            end else if (redirect_i) begin
                // Redirect wins over capture and handshake: drop every in-flight byte
                // and the current word, then restart issue at the new target.
                for (int i = 0; i < MEM_LAT; i++) begin
                    tag_v_q[i] <= 1'b0;
                end
                valid_q     <= 1'b0;
                inst_q      <= '0;
                pc_base_q   <= redirect_pc_i;
                addr_q      <= redirect_pc_i;
                ce_q        <= 1'b1;
                idx_q       <= '0;
                issue_cnt_q <= CNT_ONE;
                state_q     <= S_FETCH;
            end else begin
                // The tag of the address on the bus this cycle enters the pipe; the
                // oldest tag names the lane that d_mem_i belongs to right now.
                tag_v_q[0]   <= ce_q;
                tag_idx_q[0] <= idx_q;
                for (int i = 1; i < MEM_LAT; i++) begin
                    tag_v_q[i]   <= tag_v_q[i-1];
                    tag_idx_q[i] <= tag_idx_q[i-1];
                end

                if (state_q == S_FETCH) begin
                    if (issue_cnt_q < CNT_FULL) begin
                        addr_q      <= addr_inc_d;
                        ce_q        <= 1'b1;
                        idx_q       <= idx_q + IDX_W'(1);
                        issue_cnt_q <= issue_cnt_q + CNT_ONE;
                    end else begin
                        ce_q <= 1'b0;
                    end

                    if (tag_v_q[MEM_LAT-1]) begin
                        for (int b = 0; b < INST_BYTES; b++) begin
                            if (tag_idx_q[MEM_LAT-1] == IDX_W'(b)) begin
                                inst_q[8*b +: 8] <= d_mem_i;
                            end
                        end
                        if (tag_idx_q[MEM_LAT-1] == LAST_IDX) begin
                            state_q   <= S_HOLD;
                            valid_q   <= 1'b1;
                            inst_pc_q <= pc_base_q;
                        end
                    end
                end else if (state_q == S_HOLD && valid_q && inst_ready_i) begin
                    // Accepted: move to the next sequential word and issue it immediately.
                    valid_q     <= 1'b0;
                    pc_base_q   <= pc_next_d;
                    addr_q      <= pc_next_d;
                    ce_q        <= 1'b1;
                    idx_q       <= '0;
                    issue_cnt_q <= CNT_ONE;
                    state_q     <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        dclk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic [31:0] addr;
    logic        ce;
    logic [7:0]  d_mem;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    logic [31:0] addr2;
    logic        ce2;
    logic [7:0]  d_mem2;
    logic [15:0] inst2;
    logic [31:0] pc2;
    logic        valid2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 dclk = ~dclk;

    if_fetch_unit dut (
        .dclk          (dclk),
        .rst           (rst),
        .rdy           (rdy),
        .addr_mem_o    (addr),
        .ce_mem_o      (ce),
        .d_mem_i       (d_mem),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_o        (inst),
        .inst_pc_o     (pc),
        .inst_valid_o  (valid),
        .inst_ready_i  (ready)
    );

    if_fetch_unit #(
        .ADDR_W     (32),
        .INST_BYTES (2),
        .MEM_LAT    (3),
        .RESET_PC   (32'hFFFF_FFFF)
    ) dut2 (
        .dclk          (dclk),
        .rst           (rst),
        .rdy           (rdy),
        .addr_mem_o    (addr2),
        .ce_mem_o      (ce2),
        .d_mem_i       (d_mem2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .inst_o        (inst2),
        .inst_pc_o     (pc2),
        .inst_valid_o  (valid2),
        .inst_ready_i  (1'b1)
    );

    // Memory content: byte at address a is a[7:0] + a[15:8].
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] + a[15:8];
    endfunction

    // Byte-wide memories with fixed latency that freeze together with rdy.
    logic [31:0] ap1 [2];
    logic [31:0] ap2 [3];
    always @(posedge dclk) begin
        if (rdy) begin
            ap1[1] <= ap1[0];
            ap1[0] <= addr;
            ap2[2] <= ap2[1];
            ap2[1] <= ap2[0];
            ap2[0] <= addr2;
        end
    end
    assign d_mem  = mem_byte(ap1[1]);
    assign d_mem2 = mem_byte(ap2[2]);

    task automatic step();
        @(negedge dclk);
    endtask

    // Leaves the bench in the middle of cycle 0 (first issue cycle).
    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        repeat (2) step();
        total_cnt++;
        if ({ce, addr, valid} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL reset_ctl got ce=%b addr=%h valid=%b exp ce=0 addr=0 valid=0", ce, addr, valid);
        else pass_cnt++;
        total_cnt++;
        if ({inst, pc} !== {32'h0, 32'h0})
            $display("FAIL reset_data got inst=%h pc=%h exp 0 0", inst, pc);
        else pass_cnt++;
        total_cnt++;
        if ({ce2, addr2, valid2} !== {1'b0, 32'hFFFF_FFFF, 1'b0})
            $display("FAIL reset_dut2 got ce=%b addr=%h valid=%b exp ce=0 addr=ffffffff valid=0", ce2, addr2, valid2);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            if (c <= 3) begin
                total_cnt++;
                if ({ce, addr} !== {1'b1, 32'(c)})
                    $display("FAIL basic_issue c%0d got ce=%b addr=%h exp ce=1 addr=%h", c, ce, addr, 32'(c));
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if ({ce, valid} !== 2'b00)
                    $display("FAIL basic_idle5 got ce=%b valid=%b exp 0 0", ce, valid);
                else pass_cnt++;
            end
            if (c == 6) begin
                total_cnt++;
                if ({valid, pc, inst} !== {1'b1, 32'h0, 32'h0302_0100})
                    $display("FAIL basic_inst0 got v=%b pc=%h inst=%h exp 1 0 03020100", valid, pc, inst);
                else pass_cnt++;
            end
            if (c == 7) begin
                total_cnt++;
                if ({valid, ce, addr} !== {1'b0, 1'b1, 32'h4})
                    $display("FAIL basic_next_issue got v=%b ce=%b addr=%h exp 0 1 4", valid, ce, addr);
                else pass_cnt++;
            end
            if (c == 12) begin
                total_cnt++;
                if (valid !== 1'b0)
                    $display("FAIL basic_valid12 got %b exp 0", valid);
                else pass_cnt++;
            end
            if (c == 13) begin
                total_cnt++;
                if ({valid, pc, inst} !== {1'b1, 32'h4, 32'h0706_0504})
                    $display("FAIL basic_inst1 got v=%b pc=%h inst=%h exp 1 4 07060504", valid, pc, inst);
                else pass_cnt++;
            end
            if (c < 13) step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        repeat (6) step();
        for (int c = 6; c <= 11; c++) begin
            total_cnt++;
            if ({valid, pc, inst, ce} !== {1'b1, 32'h0, 32'h0302_0100, 1'b0})
                $display("FAIL bp_hold c%0d got v=%b pc=%h inst=%h ce=%b exp 1 0 03020100 0", c, valid, pc, inst, ce);
            else pass_cnt++;
            if (c < 11) step();
        end
        ready = 1'b1;
        step();
        total_cnt++;
        if ({valid, ce, addr} !== {1'b0, 1'b1, 32'h4})
            $display("FAIL bp_after_accept got v=%b ce=%b addr=%h exp 0 1 4", valid, ce, addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        total_cnt++;
        if ({valid, ce, addr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL redir_issue got v=%b ce=%b addr=%h exp 0 1 100", valid, ce, addr);
        else pass_cnt++;
        repeat (5) step();
        total_cnt++;
        if (valid !== 1'b0)
            $display("FAIL redir_valid9 got %b exp 0", valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({valid, pc, inst} !== {1'b1, 32'h100, 32'h0403_0201})
            $display("FAIL redir_inst got v=%b pc=%h inst=%h exp 1 100 04030201", valid, pc, inst);
        else pass_cnt++;
    endtask

    task automatic test_redirect_accept();
        do_reset();
        repeat (6) step();
        total_cnt++;
        if (valid !== 1'b1)
            $display("FAIL ra_valid6 got %b exp 1", valid);
        else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h200; ready = 1'b1;
        step();
        redirect = 1'b0;
        total_cnt++;
        if ({valid, ce, addr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL ra_issue got v=%b ce=%b addr=%h exp 0 1 200", valid, ce, addr);
        else pass_cnt++;
        repeat (6) step();
        total_cnt++;
        if ({valid, pc, inst} !== {1'b1, 32'h200, 32'h0504_0302})
            $display("FAIL ra_inst got v=%b pc=%h inst=%h exp 1 200 05040302", valid, pc, inst);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) step();
        rdy = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            total_cnt++;
            if ({ce, addr, valid} !== {1'b1, 32'h2, 1'b0})
                $display("FAIL stall_frozen c%0d got ce=%b addr=%h v=%b exp 1 2 0", c, ce, addr, valid);
            else pass_cnt++;
        end
        rdy = 1'b1;
        step();
        total_cnt++;
        if ({ce, addr} !== {1'b1, 32'h3})
            $display("FAIL stall_resume got ce=%b addr=%h exp 1 3", ce, addr);
        else pass_cnt++;
        repeat (2) step();
        total_cnt++;
        if (valid !== 1'b0)
            $display("FAIL stall_valid8 got %b exp 0", valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({valid, pc, inst} !== {1'b1, 32'h0, 32'h0302_0100})
            $display("FAIL stall_inst got v=%b pc=%h inst=%h exp 1 0 03020100", valid, pc, inst);
        else pass_cnt++;
    endtask

    task automatic test_param_sweep();
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) begin
                total_cnt++;
                if ({ce2, addr2} !== {1'b1, 32'hFFFF_FFFF})
                    $display("FAIL sweep_addr0 got ce=%b addr=%h exp 1 ffffffff", ce2, addr2);
                else pass_cnt++;
            end
            if (c == 1) begin
                total_cnt++;
                if ({ce2, addr2} !== {1'b1, 32'h0})
                    $display("FAIL sweep_wrap got ce=%b addr=%h exp 1 0", ce2, addr2);
                else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++;
                if (ce2 !== 1'b0)
                    $display("FAIL sweep_ce2 got %b exp 0", ce2);
                else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++;
                if (valid2 !== 1'b0)
                    $display("FAIL sweep_valid4 got %b exp 0", valid2);
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if ({valid2, pc2, inst2} !== {1'b1, 32'hFFFF_FFFF, 16'h00FE})
                    $display("FAIL sweep_inst0 got v=%b pc=%h inst=%h exp 1 ffffffff 00fe", valid2, pc2, inst2);
                else pass_cnt++;
            end
            if (c == 6) begin
                total_cnt++;
                if ({valid2, ce2, addr2} !== {1'b0, 1'b1, 32'h1})
                    $display("FAIL sweep_next_issue got v=%b ce=%b addr=%h exp 0 1 1", valid2, ce2, addr2);
                else pass_cnt++;
            end
            if (c == 11) begin
                total_cnt++;
                if ({valid2, pc2, inst2} !== {1'b1, 32'h1, 16'h0201})
                    $display("FAIL sweep_inst1 got v=%b pc=%h inst=%h exp 1 1 0201", valid2, pc2, inst2);
                else pass_cnt++;
            end
            if (c < 11) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_redirect_accept();
        test_stall();
        test_param_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
